e_stage_producer: RTL and testbench
===================================

// Module: e_stage_producer
// PURPOSE
//   Execute stage of the 5-stage MIPS pipeline: E pipeline register, operand forwarding from M/W,
//   ALU, and multi-cycle mult/div unit with HI/LO. Producer end of the stage-forwarding interface:
//   drives E_RFA3/E_RFWD/E_RFWr/E_Forward_Ready to the decode stage, ALU/store data to M,
//   Busy to the hazard unit.
// PARAMETERS
//   MULT_CYCLES  5   cycles Busy stays high after mult/multu is accepted
//   DIV_CYCLES   10  cycles Busy stays high after div/divu is accepted
// PORTS
//   Clk                  in   1   clock, all state on posedge
//   Rst                  in   1   synchronous, active-high global reset
//   Reg_Rst              in   1   synchronous bubble insert; clears E register only
//   IR_in, PC_in         in   32  instruction / PC from D
//   RD1_in, RD2_in       in   32  forwarded rs/rt values from D
//   EXT_in               in   32  extended immediate from D
//   M_RFA3_in            in   5   M-stage dest reg
//   M_RFWD_in            in   32  M-stage forward data
//   M_RFWr_in            in   1   M-stage write enable
//   M_Forward_Ready_in   in   1   M data valid for forwarding
//   W_RFA3_in            in   5   W-stage dest reg
//   W_RFWD_in            in   32  W-stage write data
//   W_RFWr_in            in   1   W-stage write enable
//   IR_out, PC_out       out  32  registered IR/PC to M
//   ALU_out              out  32  ALU result, or HI/LO for mfhi/mflo
//   RD2_out              out  32  forwarded rt (store data)
//   E_RFA3_out           out  5   dest reg of E instruction (0 if no write)
//   E_RFWD_out           out  32  forward data available in E
//   E_RFWr_out           out  1   E instruction writes GRF
//   E_Forward_Ready_out  out  1   E_RFWD_out valid this cycle
//   Busy_out             out  1   MDU start or in progress
// BEHAVIOUR
//   - E register (IR,PC,RD1,RD2,EXT): Rst|Reg_Rst -> all 0 (IR=0 is nop); else latch every cycle.
//   - Reset values: all outputs 0; HI=LO=0; MDU counter 0.
//   - Operand A: rs==0 -> 0; rs==M_RFA3 & M_RFWr & M_Forward_Ready -> M_RFWD;
//     rs==W_RFA3 & W_RFWr -> W_RFWD; else RD1 reg. Operand B same on rt. M beats W.
//   - ISA: addu subu and or slt sltu ori lw sw beq lui jal jr mult multu div divu mfhi mflo mthi mtlo.
//   - A3: rd for R-type writers and mfhi/mflo; rt for ori/lw/lui; 31 for jal; else 0.
//     E_RFWr_out = writer & (A3!=0).
//   - E_RFWD/Ready: jal -> PC+8, Ready=1; lui -> {IR[15:0],16'h0}, Ready=1; else 0, Ready=0.
//   - ALU: 32-bit wraparound, no overflow traps; slt signed, sltu unsigned; lw/sw -> A+EXT.
//   - MDU: Start = E holds mult/div class & counter==0. On Start edge: latch A,B;
//     counter <= MULT_CYCLES or DIV_CYCLES. Each later edge counter-1; at counter==1
//     write HI/LO, counter <= 0.
//   - Busy_out = Start | (counter!=0); high exactly N+1 cycles from E entry.
//   - mult: {HI,LO} = signed A*B; multu unsigned. div: LO=quot, HI=rem, remainder takes
//     dividend sign; divu unsigned.
//   - Divide by zero: counter runs normally, HI/LO unchanged.
//   - mthi/mtlo write HI/LO on the edge when counter==0; ignored while busy (hazard unit
//     prevents this).
//   - mfhi/mflo read committed HI/LO.
//   - Reg_Rst during an op: op continues and commits. Rst during an op: aborts; counter,
//     HI, LO <= 0.
//   - Simultaneous Start and completion cannot occur (Start requires counter==0).
// STRUCTURE
//   Shared package: opcode/funct constants, ALUOp and MDUOp encodings, instruction-class
//   decode helpers.
//   One sub-module: e_mdu (counter, operand latches, HI/LO, Busy). Forward mux, ALU and
//   A3/RFWD decode stay in top.
// TESTING
//   1. mult A=0xFFFFFFFF B=2 -> Busy high 6 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE;
//      mflo gives 0xFFFFFFFE.
//   2. div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 counts; divu 7/2 -> LO=3, HI=1;
//      divu x/0 -> HI/LO kept.
//   3. jal at PC=0x00003000 enters E -> same cycle E_RFA3=31, E_RFWD=0x00003008,
//      Ready=1, RFWr=1.
//   4. addu rs=$9 with M_RFA3=W_RFA3=9, M ready: M value used; M not ready: W value used;
//      rs=$0: 0.
//   5. Reg_Rst 2 cycles after div start -> IR_out=0, E_RFWr=0, Busy stays high, HI/LO
//      commit on schedule.
//   6. Rst mid-mult -> next cycle Busy=0, HI=LO=0, all outputs 0.

Source files
------------

// File: rtl/e_stage_producer_pkg.sv
// Shared decode for the execute stage: opcode/funct constants, ALU and MDU
// operation encodings, and instruction-class helpers.
package e_stage_producer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ORI   = 6'h0D, OP_LUI = 6'h0F, OP_LW  = 6'h23,
                         OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08, FN_MFHI = 6'h10, FN_MTHI = 6'h11,
                         FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18,
                         FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR   = 6'h25, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADDU, ALU_SUBU, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU,
    ALU_ORI, ALU_ADDI, ALU_LUI, ALU_LINK, ALU_MFHI, ALU_MFLO
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
  } mdu_op_e;

  function automatic alu_op_e decode_alu(input logic [31:0] ir);
    alu_op_e r = ALU_NOP;
    case (ir[31:26])
      OP_RTYPE:
        case (ir[5:0])
          FN_ADDU: r = ALU_ADDU;
          FN_SUBU: r = ALU_SUBU;
          FN_AND:  r = ALU_AND;
          FN_OR:   r = ALU_OR;
          FN_SLT:  r = ALU_SLT;
          FN_SLTU: r = ALU_SLTU;
          FN_MFHI: r = ALU_MFHI;
          FN_MFLO: r = ALU_MFLO;
          FN_JR:   r = ALU_NOP;
          default: r = ALU_NOP;
        endcase
      OP_ORI:       r = ALU_ORI;
      OP_LW, OP_SW: r = ALU_ADDI;
      OP_LUI:       r = ALU_LUI;
      OP_JAL:       r = ALU_LINK;
      OP_BEQ:       r = ALU_NOP;
      default:      r = ALU_NOP;
    endcase
    return r;
  endfunction

  function automatic mdu_op_e decode_mdu(input logic [31:0] ir);
    mdu_op_e r = MDU_NONE;
    if (ir[31:26] == OP_RTYPE)
      case (ir[5:0])
        FN_MULT:  r = MDU_MULT;
        FN_MULTU: r = MDU_MULTU;
        FN_DIV:   r = MDU_DIV;
        FN_DIVU:  r = MDU_DIVU;
        FN_MTHI:  r = MDU_MTHI;
        FN_MTLO:  r = MDU_MTLO;
        default:  r = MDU_NONE;
      endcase
    return r;
  endfunction

  // GRF destination of the instruction; 0 means no write
  function automatic logic [4:0] decode_dest(input logic [31:0] ir);
    logic [4:0] a3 = '0;
    case (ir[31:26])
      OP_RTYPE:
        case (ir[5:0])
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU,
          FN_MFHI, FN_MFLO: a3 = ir[15:11];
          default:          a3 = '0;
        endcase
      OP_ORI, OP_LW, OP_LUI: a3 = ir[20:16];
      OP_JAL:                a3 = 5'd31;
      default:               a3 = '0;
    endcase
    return a3;
  endfunction

  function automatic logic is_md_start(input mdu_op_e op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit: operand latches, countdown, HI/LO.
module e_mdu
  import e_stage_producer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   ra, rb;
  mdu_op_e       rop;
  logic          start;
  logic [63:0]   prod;
  logic [31:0]   quo, rem;

  assign start = is_md_start(op) && (cnt == '0);
  assign busy  = start || (cnt != '0);

  // Result datapath on the latched operands; only sampled on the final count
  always_comb begin
    prod = '0;
    quo  = '0;
    rem  = '0;
    case (rop)
      MDU_MULT:  prod = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      MDU_MULTU: prod = {32'h0, ra} * {32'h0, rb};
      MDU_DIV:   if (rb != '0) begin
                   quo = $signed(ra) / $signed(rb);
                   rem = $signed(ra) % $signed(rb);
                 end
      MDU_DIVU:  if (rb != '0) begin
                   quo = ra / rb;
                   rem = ra % rb;
                 end
      default: ;
    endcase
  end

  // Start latches operands; countdown commits HI/LO; mthi/mtlo only when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
      ra  <= '0;
      rb  <= '0;
      rop <= MDU_NONE;
    end else if (start) begin
      ra  <= a;
      rb  <= b;
      rop <= op;
      cnt <= (op == MDU_MULT || op == MDU_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (cnt == CW'(1)) begin
      cnt <= '0;
      case (rop)
        MDU_MULT, MDU_MULTU: {hi, lo} <= prod;
        MDU_DIV, MDU_DIVU:   if (rb != '0) begin
                               lo <= quo;
                               hi <= rem;
                             end
        default: ;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (op == MDU_MTHI) begin
      hi <= a;
    end else if (op == MDU_MTLO) begin
      lo <= a;
    end
  end

endmodule

// File: rtl/e_stage_producer.sv
// MIPS execute stage: E register, M/W operand forwarding, ALU, MDU, and the
// E-side producer of the stage-forwarding interface.
module e_stage_producer
  import e_stage_producer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Reg_Rst,
  input  logic [31:0] IR_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] RD1_in,
  input  logic [31:0] RD2_in,
  input  logic [31:0] EXT_in,
  input  logic [4:0]  M_RFA3_in,
  input  logic [31:0] M_RFWD_in,
  input  logic        M_RFWr_in,
  input  logic        M_Forward_Ready_in,
  input  logic [4:0]  W_RFA3_in,
  input  logic [31:0] W_RFWD_in,
  input  logic        W_RFWr_in,
  output logic [31:0] IR_out,
  output logic [31:0] PC_out,
  output logic [31:0] ALU_out,
  output logic [31:0] RD2_out,
  output logic [4:0]  E_RFA3_out,
  output logic [31:0] E_RFWD_out,
  output logic        E_RFWr_out,
  output logic        E_Forward_Ready_out,
  output logic        Busy_out
);

  logic [31:0] rd1_q, rd2_q, ext_q;
  logic [31:0] op_a, op_b, hi, lo;
  logic [4:0]  rs, rt;
  alu_op_e     alu_op;
  mdu_op_e     mdu_op;

  // E pipeline register; a bubble is all-zero (IR=0 is nop)
  always_ff @(posedge Clk) begin
    if (Rst || Reg_Rst) begin
      IR_out <= '0;
      PC_out <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      ext_q  <= '0;
    end else begin
      IR_out <= IR_in;
      PC_out <= PC_in;
      rd1_q  <= RD1_in;
      rd2_q  <= RD2_in;
      ext_q  <= EXT_in;
    end
  end

  assign rs     = IR_out[25:21];
  assign rt     = IR_out[20:16];
  assign alu_op = decode_alu(IR_out);
  assign mdu_op = decode_mdu(IR_out);

  // Operand forwarding: M beats W, $0 always reads as zero
  always_comb begin
    op_a = rd1_q;
    if (rs == '0) op_a = '0;
    else if (rs == M_RFA3_in && M_RFWr_in && M_Forward_Ready_in) op_a = M_RFWD_in;
    else if (rs == W_RFA3_in && W_RFWr_in) op_a = W_RFWD_in;
    op_b = rd2_q;
    if (rt == '0) op_b = '0;
    else if (rt == M_RFA3_in && M_RFWr_in && M_Forward_Ready_in) op_b = M_RFWD_in;
    else if (rt == W_RFA3_in && W_RFWr_in) op_b = W_RFWD_in;
  end

  assign RD2_out = op_b;

  e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_mdu (
    .clk (Clk),
    .rst (Rst),
    .op  (mdu_op),
    .a   (op_a),
    .b   (op_b),
    .hi  (hi),
    .lo  (lo),
    .busy(Busy_out)
  );

  // ALU, wraparound arithmetic; also carries HI/LO reads and link/lui values
  always_comb begin
    ALU_out = '0;
    case (alu_op)
      ALU_ADDU: ALU_out = op_a + op_b;
      ALU_SUBU: ALU_out = op_a - op_b;
      ALU_AND:  ALU_out = op_a & op_b;
      ALU_OR:   ALU_out = op_a | op_b;
      ALU_SLT:  ALU_out = {31'h0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: ALU_out = {31'h0, op_a < op_b};
      ALU_ORI:  ALU_out = op_a | ext_q;
      ALU_ADDI: ALU_out = op_a + ext_q;
      ALU_LUI:  ALU_out = {IR_out[15:0], 16'h0};
      ALU_LINK: ALU_out = PC_out + 32'd8;
      ALU_MFHI: ALU_out = hi;
      ALU_MFLO: ALU_out = lo;
      default:  ALU_out = '0;
    endcase
  end

  // Only jal and lui have their result ready already in E
  always_comb begin
    E_RFWD_out          = '0;
    E_Forward_Ready_out = 1'b0;
    case (alu_op)
      ALU_LINK: begin
        E_RFWD_out          = PC_out + 32'd8;
        E_Forward_Ready_out = 1'b1;
      end
      ALU_LUI: begin
        E_RFWD_out          = {IR_out[15:0], 16'h0};
        E_Forward_Ready_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign E_RFA3_out = decode_dest(IR_out);
  assign E_RFWr_out = (E_RFA3_out != '0);

endmodule

// File: tb/tb_e_stage_producer.sv
module tb_e_stage_producer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clk = 1'b0;
  logic        Rst, Reg_Rst;
  logic [31:0] IR_in, PC_in, RD1_in, RD2_in, EXT_in;
  logic [4:0]  M_RFA3_in, W_RFA3_in;
  logic [31:0] M_RFWD_in, W_RFWD_in;
  logic        M_RFWr_in, M_Forward_Ready_in, W_RFWr_in;
  logic [31:0] IR_out, PC_out, ALU_out, RD2_out, E_RFWD_out;
  logic [4:0]  E_RFA3_out;
  logic        E_RFWr_out, E_Forward_Ready_out, Busy_out;

  e_stage_producer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Rst(Rst), .Reg_Rst(Reg_Rst),
    .IR_in(IR_in), .PC_in(PC_in), .RD1_in(RD1_in), .RD2_in(RD2_in), .EXT_in(EXT_in),
    .M_RFA3_in(M_RFA3_in), .M_RFWD_in(M_RFWD_in), .M_RFWr_in(M_RFWr_in),
    .M_Forward_Ready_in(M_Forward_Ready_in),
    .W_RFA3_in(W_RFA3_in), .W_RFWD_in(W_RFWD_in), .W_RFWr_in(W_RFWr_in),
    .IR_out(IR_out), .PC_out(PC_out), .ALU_out(ALU_out), .RD2_out(RD2_out),
    .E_RFA3_out(E_RFA3_out), .E_RFWD_out(E_RFWD_out), .E_RFWr_out(E_RFWr_out),
    .E_Forward_Ready_out(E_Forward_Ready_out), .Busy_out(Busy_out)
  );

  always #5 Clk = ~Clk;

  int nvec = 0, nmis = 0;
  bit chk_en = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] a, b, alu, rfwd;
    logic [4:0]  a3;
    logic        wr, rdy, md, mthi, mtlo, busy;
  } exp_t;

  logic [31:0] m_ir, m_pc, m_rd1, m_rd2, m_ext, m_hi, m_lo, p_hi, p_lo;
  bit          m_act = 1'b0, p_wr;
  int          m_edge = 0, m_done = 0;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 5'd0) return 32'd0;
    if (r == M_RFA3_in && M_RFWr_in && M_Forward_Ready_in) return M_RFWD_in;
    if (r == W_RFA3_in && W_RFWr_in) return W_RFWD_in;
    return v;
  endfunction

  function automatic exp_t model_eval();
    exp_t x;
    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    x  = '0;
    op = m_ir[31:26]; fn = m_ir[5:0]; rt = m_ir[20:16]; rd = m_ir[15:11];
    x.a = fwd(m_ir[25:21], m_rd1);
    x.b = fwd(rt, m_rd2);
    if (op == 6'h00) begin
      case (fn)
        6'h21: begin x.alu = x.a + x.b; x.a3 = rd; end
        6'h23: begin x.alu = x.a - x.b; x.a3 = rd; end
        6'h24: begin x.alu = x.a & x.b; x.a3 = rd; end
        6'h25: begin x.alu = x.a | x.b; x.a3 = rd; end
        6'h2A: begin x.alu = ($signed(x.a) < $signed(x.b)) ? 32'd1 : 32'd0; x.a3 = rd; end
        6'h2B: begin x.alu = (x.a < x.b) ? 32'd1 : 32'd0; x.a3 = rd; end
        6'h10: begin x.alu = m_hi; x.a3 = rd; end
        6'h12: begin x.alu = m_lo; x.a3 = rd; end
        6'h18, 6'h19, 6'h1A, 6'h1B: x.md = 1'b1;
        6'h11: x.mthi = 1'b1;
        6'h13: x.mtlo = 1'b1;
        default: ;
      endcase
    end else if (op == 6'h0D) begin x.alu = x.a | m_ext; x.a3 = rt;
    end else if (op == 6'h23) begin x.alu = x.a + m_ext; x.a3 = rt;
    end else if (op == 6'h2B) begin x.alu = x.a + m_ext;
    end else if (op == 6'h0F) begin
      x.alu = {m_ir[15:0], 16'h0}; x.rfwd = x.alu; x.rdy = 1'b1; x.a3 = rt;
    end else if (op == 6'h03) begin
      x.alu = m_pc + 32'd8; x.rfwd = x.alu; x.rdy = 1'b1; x.a3 = 5'd31;
    end
    x.wr   = (x.a3 != 5'd0);
    x.busy = m_act || x.md;
    return x;
  endfunction

  // model state advance: MDU op timestamped by the edge it will finish on
  always @(posedge Clk) begin : mdl
    exp_t x;
    int sa, sb;
    longint p;
    logic [63:0] pu;
    x = model_eval();
    if (Rst) begin
      m_ir = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_ext = 0;
      m_hi = 0; m_lo = 0; m_act = 1'b0;
    end else begin
      if (m_act && m_edge == m_done) begin
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        m_act = 1'b0;
      end else if (!m_act && x.md) begin
        sa = x.a; sb = x.b; p_wr = 1'b1;
        case (m_ir[5:0])
          6'h18: begin p = longint'(sa) * longint'(sb); p_hi = p[63:32]; p_lo = p[31:0]; end
          6'h19: begin pu = {32'h0, x.a} * {32'h0, x.b}; p_hi = pu[63:32]; p_lo = pu[31:0]; end
          6'h1A: if (sb != 0) begin p_lo = sa / sb; p_hi = sa % sb; end else p_wr = 1'b0;
          default: if (x.b != 0) begin p_lo = x.a / x.b; p_hi = x.a % x.b; end else p_wr = 1'b0;
        endcase
        m_done = m_edge + ((m_ir[5:0] == 6'h18 || m_ir[5:0] == 6'h19) ? MC : DC);
        m_act  = 1'b1;
      end else if (!m_act && x.mthi) m_hi = x.a;
      else if (!m_act && x.mtlo) m_lo = x.a;
      if (Reg_Rst) begin
        m_ir = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_ext = 0;
      end else begin
        m_ir = IR_in; m_pc = PC_in; m_rd1 = RD1_in; m_rd2 = RD2_in; m_ext = EXT_in;
      end
    end
    m_edge++;
  end

  // per-cycle compare against the model
  always @(negedge Clk) begin
    if (chk_en) begin : cmp
      exp_t x;
      x = model_eval();
      chk("m_ir",   IR_out, m_ir);
      chk("m_pc",   PC_out, m_pc);
      chk("m_alu",  ALU_out, x.alu);
      chk("m_rd2",  RD2_out, x.b);
      chk("m_a3",   {27'd0, E_RFA3_out}, {27'd0, x.a3});
      chk("m_rfwd", E_RFWD_out, x.rfwd);
      chk("m_rfwr", {31'd0, E_RFWr_out}, {31'd0, x.wr});
      chk("m_rdy",  {31'd0, E_Forward_Ready_out}, {31'd0, x.rdy});
      chk("m_busy", {31'd0, Busy_out}, {31'd0, x.busy});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic issue(input logic [31:0] ir, input logic [31:0] a, b, e);
    IR_in = ir; RD1_in = a; RD2_in = b; EXT_in = e; PC_in = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    @(posedge Clk); #1;
  endtask

  task automatic count_busy(input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      issue(32'd0, 32'd0, 32'd0, 32'd0);
      if (Busy_out) k++;
    end
  endtask

  task automatic fwd_clear();
    M_RFA3_in = 0; M_RFWD_in = 0; M_RFWr_in = 0; M_Forward_Ready_in = 0;
    W_RFA3_in = 0; W_RFWD_in = 0; W_RFWr_in = 0;
  endtask

  logic [31:0] t_ir[12], t_a[12], t_b[12], t_e[12], t_x[12];
  logic        t_w[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, k;
    Rst = 1; Reg_Rst = 0;
    IR_in = 0; PC_in = 0; RD1_in = 0; RD2_in = 0; EXT_in = 0;
    fwd_clear();
    @(posedge Clk); #1;
    chk_en = 1'b1;
    @(posedge Clk); #1;
    chk("rst_ir",   IR_out, 32'd0);
    chk("rst_pc",   PC_out, 32'd0);
    chk("rst_alu",  ALU_out, 32'd0);
    chk("rst_rd2",  RD2_out, 32'd0);
    chk("rst_rfwd", E_RFWD_out, 32'd0);
    chk("rst_flags", {28'd0, E_RFA3_out == 0, E_RFWr_out, E_Forward_Ready_out, Busy_out}, 32'h8);
    Rst = 0;

    // ALU table with hand-computed results
    t_ir = '{enc_r(1,2,3,6'h21), enc_r(1,2,3,6'h23), enc_r(1,2,3,6'h24), enc_r(1,2,3,6'h25),
             enc_r(1,2,3,6'h2A), enc_r(1,2,3,6'h2B), enc_i(6'h0D,1,4,16'h00FF),
             enc_i(6'h23,1,4,16'h0008), enc_i(6'h2B,1,4,16'hFFFC), enc_i(6'h0F,0,4,16'hABCD),
             enc_i(6'h04,1,2,16'h0010), enc_r(1,0,0,6'h08)};
    t_a  = '{32'hFFFFFFFF, 32'd1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'h12340000, 32'h1000, 32'h1000, 32'd0, 32'd5, 32'h3000};
    t_b  = '{32'd2, 32'd2, 32'h0FF00FF0, 32'h0FF00FF0, 32'd1, 32'd1, 0, 0, 32'h77, 0, 32'd5, 0};
    t_e  = '{0, 0, 0, 0, 0, 0, 32'h000000FF, 32'd8, 32'hFFFFFFFC, 0, 32'h10, 0};
    t_x  = '{32'd1, 32'hFFFFFFFF, 32'h00F000F0, 32'hFFF0FFF0, 32'd1, 32'd0, 32'h123400FF,
             32'h1008, 32'h0FFC, 32'hABCD0000, 32'd0, 32'd0};
    t_w  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      issue(t_ir[i], t_a[i], t_b[i], t_e[i]);
      chk($sformatf("alu_%0d", i), ALU_out, t_x[i]);
      chk($sformatf("wr_%0d", i), {31'd0, E_RFWr_out}, {31'd0, t_w[i]});
    end

    // mult -1 * 2
    issue(enc_r(1,2,0,6'h18), 32'hFFFFFFFF, 32'd2, 0);
    nb = Busy_out; count_busy(12, k);
    chk("mult_busy_cycles", nb + k, 6);
    issue(enc_r(0,0,3,6'h12), 0, 0, 0);
    chk("mult_lo", ALU_out, 32'hFFFFFFFE);
    chk("mflo_a3", {27'd0, E_RFA3_out}, 32'd3);
    issue(enc_r(0,0,3,6'h10), 0, 0, 0);
    chk("mult_hi", ALU_out, 32'hFFFFFFFF);

    // div -7/2, divu 7/2, divu 5/0
    issue(enc_r(1,2,0,6'h1A), 32'hFFFFFFF9, 32'd2, 0);
    nb = Busy_out; count_busy(14, k);
    chk("div_busy_cycles", nb + k, 11);
    issue(enc_r(0,0,3,6'h12), 0, 0, 0); chk("div_lo", ALU_out, 32'hFFFFFFFD);
    issue(enc_r(0,0,3,6'h10), 0, 0, 0); chk("div_hi", ALU_out, 32'hFFFFFFFF);
    issue(enc_r(1,2,0,6'h1B), 32'd7, 32'd2, 0); count_busy(12, k);
    issue(enc_r(0,0,3,6'h12), 0, 0, 0); chk("divu_lo", ALU_out, 32'd3);
    issue(enc_r(0,0,3,6'h10), 0, 0, 0); chk("divu_hi", ALU_out, 32'd1);
    issue(enc_r(1,2,0,6'h1B), 32'd5, 32'd0, 0); count_busy(12, k);
    issue(enc_r(0,0,3,6'h12), 0, 0, 0); chk("div0_lo", ALU_out, 32'd3);
    issue(enc_r(0,0,3,6'h10), 0, 0, 0); chk("div0_hi", ALU_out, 32'd1);

    // mthi then mfhi
    issue(enc_r(4,0,0,6'h11), 32'h12345678, 0, 0);
    issue(enc_r(0,0,5,6'h10), 0, 0, 0);
    chk("mthi_mfhi", ALU_out, 32'h12345678);

    // jal
    pc_ctr = 32'h0000_3000;
    issue({6'h03, 26'h0000C40}, 0, 0, 0);
    chk("jal_a3",   {27'd0, E_RFA3_out}, 32'd31);
    chk("jal_rfwd", E_RFWD_out, 32'h00003008);
    chk("jal_rdy",  {31'd0, E_Forward_Ready_out}, 32'd1);
    chk("jal_wr",   {31'd0, E_RFWr_out}, 32'd1);

    // forwarding priority
    issue(enc_r(9,0,10,6'h21), 32'h11111111, 0, 0);
    M_RFA3_in = 9; M_RFWr_in = 1; M_Forward_Ready_in = 1; M_RFWD_in = 32'hAAAA0000;
    W_RFA3_in = 9; W_RFWr_in = 1; W_RFWD_in = 32'h0000BBBB;
    #1 chk("fwd_m", ALU_out, 32'hAAAA0000);
    M_Forward_Ready_in = 0;
    #1 chk("fwd_w", ALU_out, 32'h0000BBBB);
    M_Forward_Ready_in = 1;
    issue(enc_i(6'h2B,0,9,16'h0004), 0, 32'h33333333, 32'd4);
    chk("fwd_rt_m", RD2_out, 32'hAAAA0000);
    M_RFA3_in = 0; M_RFWD_in = 32'hDEADBEEF; W_RFA3_in = 0;
    issue(enc_r(0,0,10,6'h21), 32'h11111111, 32'h22222222, 0);
    chk("fwd_zero", ALU_out, 32'd0);
    fwd_clear();

    // Reg_Rst while div in flight
    issue(enc_r(1,2,0,6'h1A), 32'd100, 32'd7, 0);
    nb = Busy_out;
    issue(0, 0, 0, 0); nb += Busy_out;
    Reg_Rst = 1;
    issue(enc_i(6'h0D,1,5,16'h0001), 32'd1, 0, 32'd1);
    Reg_Rst = 0;
    chk("bub_ir", IR_out, 32'd0);
    chk("bub_wr", {31'd0, E_RFWr_out}, 32'd0);
    chk("bub_busy", {31'd0, Busy_out}, 32'd1);
    nb += Busy_out; count_busy(12, k);
    chk("bub_busy_cycles", nb + k, 11);
    issue(enc_r(0,0,3,6'h12), 0, 0, 0); chk("bub_lo", ALU_out, 32'd14);
    issue(enc_r(0,0,3,6'h10), 0, 0, 0); chk("bub_hi", ALU_out, 32'd2);

    // Rst mid-mult
    issue(enc_r(1,2,0,6'h18), 32'd3, 32'd4, 0);
    issue(0, 0, 0, 0); issue(0, 0, 0, 0);
    Rst = 1;
    issue(enc_r(1,2,3,6'h21), 32'd5, 32'd6, 0);
    Rst = 0;
    chk("rst_busy", {31'd0, Busy_out}, 32'd0);
    chk("rst2_ir",  IR_out, 32'd0);
    chk("rst2_pc",  PC_out, 32'd0);
    chk("rst2_alu", ALU_out, 32'd0);
    count_busy(8, k);
    chk("rst_no_busy", k, 0);
    issue(enc_r(0,0,3,6'h10), 0, 0, 0); chk("rst_hi", ALU_out, 32'd0);
    issue(enc_r(0,0,3,6'h12), 0, 0, 0); chk("rst_lo", ALU_out, 32'd0);

    @(posedge Clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
